// File: rtl/uberlut_pkg.sv
// Shared types and sizing for the UberLUT loader and the UberLUT it feeds.
// Latency: n/a (types, constants and a compile-time sizing function only).
// Backpressure: n/a.
// Contents: state_t (loader FSM states), CRC8_POLY, total_bits() which gives the
// number of UberLUT variable-RAM bits; the UberLUT sizes itself with the same function.
package uberlut_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One RAM bit per (selector, variable combination).
  function automatic int total_bits(input int num_vars, input int num_varsel);
    return num_varsel * (1 << num_vars);
  endfunction

endpackage

// File: rtl/uberlut_loader_if.sv
// Host-side byte stream into the UberLUT loader: session start plus valid/ready bytes.
// Latency: n/a (wiring only).
// Backpressure: s_ready from the loader; the host holds s_data/s_valid until accepted.
// Ports: start (one-cycle session pulse), s_data[7:0], s_valid, s_ready.
// Modports: master = host/boot stream side, slave = loader side.
interface uberlut_loader_if;
  logic       start;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output start, output s_data, output s_valid, input s_ready);
  modport slave  (input start, input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uberlut_loader_crc8_byte.sv
// CRC-8 next-state over one byte, MSB first, polynomial CRC8_POLY.
// Latency: combinational.
// Backpressure: none.
// Ports: crc_in (running CRC), data_in (byte), crc_out (CRC after absorbing data_in).
module crc8_byte
  import uberlut_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/uberlut_loader.sv
// Serializes config bytes LSB-first into the UberLUT uberLUT_data/uberLUT_load port, TOTAL_BITS pulses per session.
// Latency: byte accepted in cycle N gives load pulses in N+1..N+8; the next byte can be accepted in N+8 (no gap).
// Backpressure: s_ready only in FILL and on the last bit of a byte; host stalls simply hold the FSM in FILL.
// Ports: clk, rst (async, active low), bus (uberlut_loader_if.slave: start, s_data, s_valid, s_ready),
//   uberLUT_data/uberLUT_load (serial bit + strobe), busy, done (held until next start), bit_count.
// Optional: UBERLUT_LOADER_CRC_EN adds a trailing CRC-8 byte check and the crc_err output.
module uberlut_loader
  import uberlut_pkg::*;
#(
  parameter  int NUM_VARS   = 6,
  parameter  int NUM_VARSEL = 2,
  localparam int TOTAL_BITS = total_bits(NUM_VARS, NUM_VARSEL),
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  uberlut_loader_if.slave  bus,
  output logic             uberLUT_data,
  output logic             uberLUT_load,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
`ifdef UBERLUT_LOADER_CRC_EN
  ,
  output logic             crc_err
`endif
);

  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL_BITS);

  state_t           state, state_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [2:0]       byte_bits, byte_bits_nxt;   // bits of the byte still to go after the current pulse
  logic [CNT_W-1:0] bit_count_nxt;
  logic             load_nxt, data_nxt, busy_nxt, done_nxt;
  logic             s_ready_q, s_ready_nxt;
  logic             hs, all_issued, take, emit, restart;
  logic [2:0]       first_bits;
  int               remaining;

  assign bus.s_ready = s_ready_q;
  assign hs          = bus.s_valid & s_ready_q;
  // bit_count already includes the pulse currently on the output.
  assign all_issued  = (bit_count == TOTAL_CNT);

  // A short final byte only contributes TOTAL_BITS - bit_count bits; the first goes out immediately.
  always_comb begin
    remaining  = TOTAL_BITS - int'(bit_count);
    first_bits = (remaining >= 8) ? 3'd7 : 3'(remaining - 1);
  end

`ifdef UBERLUT_LOADER_CRC_EN
  logic [7:0] crc_q, crc_nxt, crc_calc;
  logic       crc_err_nxt, crc_hs;

  crc8_byte u_crc8 (
    .crc_in  (crc_q),
    .data_in (bus.s_data),
    .crc_out (crc_calc)
  );
`endif

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    byte_bits_nxt = byte_bits;
    bit_count_nxt = bit_count;
    load_nxt      = 1'b0;
    data_nxt      = 1'b0;
    done_nxt      = done;
    take          = 1'b0;
    emit          = 1'b0;
    restart       = 1'b0;
`ifdef UBERLUT_LOADER_CRC_EN
    crc_nxt       = crc_q;
    crc_err_nxt   = crc_err;
    crc_hs        = 1'b0;
`endif

    case (state)
      IDLE, DONE: begin
        if (bus.start) restart = 1'b1;
      end
      FILL: begin
        if (hs && !all_issued) take = 1'b1;
`ifdef UBERLUT_LOADER_CRC_EN
        // With every config bit out, the byte in FILL is the trailing CRC.
        if (hs && all_issued) crc_hs = 1'b1;
`endif
      end
      SHIFT: begin
        if (byte_bits != 3'd0) begin
          emit = 1'b1;
        end else if (hs) begin
          // Lookahead reload: keeps the load train unbroken.
          take = 1'b1;
        end else if (!all_issued) begin
          state_nxt = FILL;
        end else begin
`ifdef UBERLUT_LOADER_CRC_EN
          state_nxt = FILL;
`else
          state_nxt = DONE;
          done_nxt  = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (restart) begin
      state_nxt     = FILL;
      bit_count_nxt = '0;
      done_nxt      = 1'b0;
`ifdef UBERLUT_LOADER_CRC_EN
      crc_nxt       = 8'h00;
      crc_err_nxt   = 1'b0;
`endif
    end

    if (take) begin
      state_nxt     = SHIFT;
      load_nxt      = 1'b1;
      data_nxt      = bus.s_data[0];
      shreg_nxt     = {1'b0, bus.s_data[7:1]};
      byte_bits_nxt = first_bits;
      bit_count_nxt = bit_count + CNT_W'(1);
`ifdef UBERLUT_LOADER_CRC_EN
      crc_nxt       = crc_calc;
`endif
    end

    if (emit) begin
      load_nxt      = 1'b1;
      data_nxt      = shreg[0];
      shreg_nxt     = {1'b0, shreg[7:1]};
      byte_bits_nxt = byte_bits - 3'd1;
      if (!all_issued) bit_count_nxt = bit_count + CNT_W'(1);
    end

`ifdef UBERLUT_LOADER_CRC_EN
    if (crc_hs) begin
      state_nxt   = DONE;
      done_nxt    = 1'b1;
      crc_err_nxt = (bus.s_data != crc_q);
    end
`endif

    busy_nxt    = (state_nxt == FILL) || (state_nxt == SHIFT);
    s_ready_nxt = (state_nxt == FILL) ||
                  ((state_nxt == SHIFT) && (byte_bits_nxt == 3'd0) && (bit_count_nxt != TOTAL_CNT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shreg        <= '0;
      byte_bits    <= '0;
      bit_count    <= '0;
      uberLUT_load <= 1'b0;
      uberLUT_data <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      s_ready_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      byte_bits    <= byte_bits_nxt;
      bit_count    <= bit_count_nxt;
      uberLUT_load <= load_nxt;
      uberLUT_data <= data_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      s_ready_q    <= s_ready_nxt;
    end
  end

`ifdef UBERLUT_LOADER_CRC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q   <= 8'h00;
      crc_err <= 1'b0;
    end else begin
      crc_q   <= crc_nxt;
      crc_err <= crc_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uberlut_loader.sv
// Bench for uberlut_loader: a 16-bit instance (NUM_VARS=3, NUM_VARSEL=2) and a 12-bit one (2, 3).
// Expected serial bits are queued when a byte handshake is seen and popped on each load pulse.
module tb_uberlut_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  uberlut_loader_if ifa ();
  uberlut_loader_if ifb ();

  logic       load_a, data_a, busy_a, done_a;
  logic [4:0] bc_a;
  logic       load_b, data_b, busy_b, done_b;
  logic [3:0] bc_b;
`ifdef UBERLUT_LOADER_CRC_EN
  logic       crc_a, crc_b;
`endif

  uberlut_loader #(.NUM_VARS(3), .NUM_VARSEL(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .uberLUT_data(data_a), .uberLUT_load(load_a),
    .busy(busy_a), .done(done_a), .bit_count(bc_a)
`ifdef UBERLUT_LOADER_CRC_EN
    , .crc_err(crc_a)
`endif
  );

  uberlut_loader #(.NUM_VARS(2), .NUM_VARSEL(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .uberLUT_data(data_b), .uberLUT_load(load_b),
    .busy(busy_b), .done(done_b), .bit_count(bc_b)
`ifdef UBERLUT_LOADER_CRC_EN
    , .crc_err(crc_b)
`endif
  );

  // The test drives one instance at a time; sel picks which one is observed.
  logic       sel = 1'b0;
  wire        rdy_m  = sel ? ifb.s_ready : ifa.s_ready;
  wire        load_m = sel ? load_b : load_a;
  wire        data_m = sel ? data_b : data_a;
  wire        busy_m = sel ? busy_b : busy_a;
  wire        done_m = sel ? done_b : done_a;
  wire [4:0]  bc_m   = sel ? {1'b0, bc_b} : bc_a;
`ifdef UBERLUT_LOADER_CRC_EN
  wire        crc_m  = sel ? crc_b : crc_a;
`endif

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int pulses, ones, first_cyc, last_cyc;
  bit exp_q[$];

  typedef struct {
    bit         s;
    logic [7:0] b0;
    logic [7:0] b1;
    int         gap;
    bit         disturb;
    logic [7:0] crc_x;
    int         exp_p;
    int         exp_ones;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic set_in(input logic st, input logic v, input logic [7:0] d);
    if (sel) begin
      ifb.start = st; ifb.s_valid = v; ifb.s_data = d;
    end else begin
      ifa.start = st; ifa.s_valid = v; ifa.s_data = d;
    end
  endtask

`ifdef UBERLUT_LOADER_CRC_EN
  function automatic logic [7:0] crc8m(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    return x;
  endfunction
`endif

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard consumer: every load pulse must match the next queued bit.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && load_m === 1'b1) begin
        pulses++;
        ones += int'(data_m);
        if (pulses == 1) first_cyc = cyc;
        last_cyc = cyc;
        chk("bit_count_vs_pulses", int'(bc_m), pulses);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_data", int'(data_m), int'(e));
        end
      end
    end
  end

  // Wait for s_ready with s_valid up; the handshake lands on the next posedge.
  task automatic wait_hs(input logic [7:0] d, input bit push, input int tot, inout int mcnt);
    int n;
    for (int k = 0; k < 40; k++) begin
      if (rdy_m) break;
      @(negedge clk);
    end
    if (!rdy_m) begin
      chk("s_ready_timeout", 0, 1);
    end else if (push) begin
      n = (tot - mcnt > 8) ? 8 : tot - mcnt;
      for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
      mcnt += n;
    end
    @(negedge clk);
  endtask

  task automatic run_session(input vec_t v);
    int tot, mcnt, done_cyc, hs_cyc;
    bit got;
    sel = v.s;
    tot = v.s ? 12 : 16;
    mcnt = 0; hs_cyc = 0;
    pulses = 0; ones = 0; first_cyc = 0; last_cyc = 0;
    exp_q.delete();
    set_in(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("busy_after_start", int'(busy_m), 1);
    chk("bit_count_after_start", int'(bc_m), 0);
    set_in(1'b0, 1'b1, v.b0);
    wait_hs(v.b0, 1'b1, tot, mcnt);
    if (v.disturb) begin
      set_in(1'b1, 1'b1, v.b1);
      @(negedge clk);
    end
    if (v.gap > 0) begin
      set_in(1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 40; k++) begin
        if (rdy_m && !load_m) break;
        @(negedge clk);
      end
      for (int g = 0; g < v.gap; g++) begin
        chk("gap_load_low", int'(load_m), 0);
        @(negedge clk);
      end
    end
    set_in(1'b0, 1'b1, v.b1);
    wait_hs(v.b1, 1'b1, tot, mcnt);
`ifdef UBERLUT_LOADER_CRC_EN
    set_in(1'b0, 1'b1, crc8m(crc8m(8'h00, v.b0), v.b1) ^ v.crc_x);
    wait_hs(8'h00, 1'b0, tot, mcnt);
    hs_cyc = cyc - 1;
`endif
    set_in(1'b0, 1'b0, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done_m) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("done_seen", int'(got), 1);
    done_cyc = cyc;
`ifdef UBERLUT_LOADER_CRC_EN
    chk("done_after_crc_byte", done_cyc, hs_cyc + 1);
    chk("crc_err", int'(crc_m), (v.crc_x != 8'h00) ? 1 : 0);
`else
    chk("done_after_last_pulse", done_cyc, last_cyc + 1);
`endif
    chk("pulse_count", pulses, v.exp_p);
    chk("ones_count", ones, v.exp_ones);
    chk("final_bit_count", int'(bc_m), tot);
    chk("busy_at_done", int'(busy_m), 0);
    chk("s_ready_at_done", int'(rdy_m), 0);
    chk("leftover_expected_bits", exp_q.size(), 0);
    if (v.gap == 0) chk("contiguous_train", last_cyc - first_cyc + 1, v.exp_p);
    set_in(1'b0, 1'b1, 8'h55);   // s_valid in DONE must not be taken
    repeat (3) @(negedge clk);
    set_in(1'b0, 1'b0, 8'h00);
    chk("done_held", int'(done_m), 1);
    chk("s_ready_in_done", int'(rdy_m), 0);
    chk("no_pulse_in_done", pulses, v.exp_p);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int mcnt;
    vecs[0] = '{1'b0, 8'hA5, 8'h3C, 0, 1'b0, 8'h00, 16, 8};
    vecs[1] = '{1'b1, 8'hFF, 8'h0F, 0, 1'b0, 8'h00, 12, 12};
    vecs[2] = '{1'b0, 8'h00, 8'hFF, 5, 1'b0, 8'h00, 16, 8};
    vecs[3] = '{1'b0, 8'hA5, 8'h3C, 0, 1'b1, 8'h00, 16, 8};
    vecs[4] = '{1'b0, 8'h80, 8'h01, 2, 1'b0, 8'h00, 16, 2};
    vecs[5] = '{1'b0, 8'hA5, 8'h3C, 0, 1'b0, 8'h01, 16, 8};

    ifa.start = 1'b0; ifa.s_valid = 1'b0; ifa.s_data = 8'h00;
    ifb.start = 1'b0; ifb.s_valid = 1'b0; ifb.s_data = 8'h00;
    pulses = 0; ones = 0; first_cyc = 0; last_cyc = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load", int'(load_a), 0);
    chk("rst_data", int'(data_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_s_ready", int'(ifa.s_ready), 0);
    chk("rst_bit_count", int'(bc_a), 0);
    rst = 1'b1;
    @(negedge clk);

    // s_valid while IDLE: not accepted, no pulses.
    sel = 1'b0;
    set_in(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_s_ready", int'(rdy_m), 0);
      chk("idle_load", int'(load_m), 0);
    end
    set_in(1'b0, 1'b0, 8'h00);

    // Reset after five pulses of the first byte.
    mcnt = 0; pulses = 0; ones = 0; exp_q.delete();
    set_in(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    set_in(1'b0, 1'b1, 8'hA5);
    wait_hs(8'hA5, 1'b1, 16, mcnt);
    set_in(1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_pulses_before_rst", pulses, 5);
    chk("abort_load", int'(load_a), 0);
    chk("abort_data", int'(data_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_done", int'(done_a), 0);
    chk("abort_s_ready", int'(ifa.s_ready), 0);
    chk("abort_bit_count", int'(bc_a), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_bit_count", int'(bc_a), 0);
    chk("post_rst_busy", int'(busy_a), 0);
    chk("post_rst_s_ready", int'(ifa.s_ready), 0);
    chk("post_rst_no_pulses", pulses, 5);

    for (int i = 0; i < 6; i++) run_session(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
